modbus_rtu_rx_framer: RTL and testbench

Receive-side Modbus RTU framer. It sits between the UART byte receiver and the request decoder. It delimits frames by inter-character silence, checks CRC-16/MODBUS, and checks the slave address (own address or broadcast 0). Only validated frames are released downstream from an internal buffer, as a byte stream with the CRC bytes removed.

---
 rtl/modbus_rtu_rx_framer_if.sv | 22 ++
 rtl/modbus_rtu_rx_framer.sv | 143 ++++++++++++++
 tb/tb_modbus_rtu_rx_framer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_rtu_rx_framer_if.sv
// modbus_rtu_rx_framer_if: UART receive strobes in, validated frame byte stream out
interface modbus_rtu_rx_framer_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_rx_err;
    logic [7:0] i_my_addr;
    logic       i_m_ready;
    logic [7:0] o_m_data;
    logic       o_m_valid;
    logic       o_m_last;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic       o_busy;
    modport master (
        output i_rx_data, i_rx_valid, i_rx_err, i_my_addr, i_m_ready,
        input  o_m_data, o_m_valid, o_m_last, o_frame_ok, o_frame_err, o_busy
    );
    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_err, i_my_addr, i_m_ready,
        output o_m_data, o_m_valid, o_m_last, o_frame_ok, o_frame_err, o_busy
    );
endinterface

// File: rtl/modbus_rtu_rx_framer.sv
// modbus_rtu_rx_framer: silence-delimited Modbus RTU frames, CRC/address check, buffered delivery
module modbus_rtu_rx_framer #(
    parameter int T15_CYCLES = 20625,
    parameter int T35_CYCLES = 48125,
    parameter int MAX_LEN    = 256
) (
    input logic clk,
    input logic rst,
    modbus_rtu_rx_framer_if.slave bus
);
    localparam int GW = $clog2(T35_CYCLES + 1);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [GW-1:0] T15_G = GW'(T15_CYCLES);
    localparam logic [GW-1:0] T35_G = GW'(T35_CYCLES);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RECEIVE, S_CHECK, S_DELIVER} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gap;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_rd;
    logic [15:0]     r_crc;
    logic            r_err;
    logic [7:0]      r_byte0;
    logic [7:0]      r_mem [MAX_LEN];
    logic [7:0]      r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic            r_busy;

    logic [15:0]     w_crc_next;
    logic [LW-1:0]   w_last_idx;
    logic            w_good;
    logic            w_fetch;
    logic            w_wr;
    logic [AW-1:0]   w_wr_idx;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        return x;
    endfunction

    assign w_crc_next = crc_byte((r_state == S_IDLE) ? 16'hFFFF : r_crc, bus.i_rx_data);
    assign w_last_idx = r_len - LW'(3);
    assign w_good     = !r_err && r_len >= LW'(4) && r_crc == 16'h0000 &&
                        (r_byte0 == bus.i_my_addr || r_byte0 == 8'h00);
    assign w_fetch    = r_state == S_DELIVER && r_rd <= w_last_idx && (!r_m_valid || bus.i_m_ready);
    assign w_wr       = bus.i_rx_valid && (r_state == S_IDLE || (r_state == S_RECEIVE && r_len != MAX_L));
    assign w_wr_idx   = (r_state == S_IDLE) ? '0 : r_len[AW-1:0];

    // Silence timer: any line activity restarts it, saturates at the end-of-frame gap
    always_ff @(posedge clk) begin
        if (!rst) r_gap <= '0;
        else if (bus.i_rx_valid || bus.i_rx_err) r_gap <= '0;
        else if (r_gap != T35_G) r_gap <= r_gap + GW'(1);
    end

    // Frame buffer: opening byte at index 0, later bytes at index len until full
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_wr_idx] <= bus.i_rx_data;
    end

    // Framing FSM: wait for silence, collect, validate once, then stream the payload
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_len       <= '0;
            r_rd        <= '0;
            r_crc       <= '0;
            r_err       <= 1'b0;
            r_byte0     <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_busy <= r_gap != T35_G;
                    if (r_gap == T35_G) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.i_rx_valid) begin
                        r_state <= S_RECEIVE;
                        r_busy  <= 1'b1;
                        r_len   <= LW'(1);
                        r_crc   <= w_crc_next;
                        r_byte0 <= bus.i_rx_data;
                        r_err   <= bus.i_rx_err;
                    end
                end
                S_RECEIVE: begin
                    if (bus.i_rx_valid) begin
                        if (r_gap > T15_G || r_len == MAX_L || bus.i_rx_err) r_err <= 1'b1;
                        if (r_len != MAX_L) r_len <= r_len + LW'(1);
                        r_crc <= w_crc_next;
                    end else if (bus.i_rx_err) begin
                        r_err <= 1'b1;
                    end else if (r_gap == T35_G) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_frame_ok  <= w_good;
                    r_frame_err <= !w_good;
                    r_busy      <= w_good;
                    r_rd        <= '0;
                    r_state     <= w_good ? S_DELIVER : S_IDLE;
                end
                S_DELIVER: begin
                    if (w_fetch) begin
                        r_m_data  <= r_mem[r_rd[AW-1:0]];
                        r_m_last  <= r_rd == w_last_idx;
                        r_m_valid <= 1'b1;
                        r_rd      <= r_rd + LW'(1);
                    end else if (r_m_valid && bus.i_m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) r_state <= S_INIT;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.o_m_data    = r_m_data;
    assign bus.o_m_valid   = r_m_valid;
    assign bus.o_m_last    = r_m_last;
    assign bus.o_frame_ok  = r_frame_ok;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_busy      = r_busy;
endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// tb_modbus_rtu_rx_framer: directed and random frames against a frame-level reference model
module tb_modbus_rtu_rx_framer;
    localparam int T15 = 15;
    localparam int T35 = 35;
    localparam int MAX_LEN = 16;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   fails;
    int   xfer;
    int   rdy_mode;
    bit         exp_ev[$];
    int         exp_c[$];
    logic [8:0] exp_b[$];
    bq_t  f1;
    bq_t  f;

    modbus_rtu_rx_framer_if bus();

    modbus_rtu_rx_framer #(.T15_CYCLES(T15), .T35_CYCLES(T35), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc16(input bq_t q);
        int c;
        c = 'hFFFF;
        foreach (q[i]) begin
            c = c ^ int'(q[i]);
            repeat (8) c = (c % 2 == 1) ? ((c / 2) ^ 'hA001) : (c / 2);
        end
        return 16'(c);
    endfunction

    function automatic bq_t with_crc(input bq_t p);
        bq_t r;
        logic [15:0] c;
        r = p;
        c = crc16(p);
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bq_t q, input int sp, input int la, input int ls,
                             input int ea, input bit alone, input int mode);
        int n, s, idle, lc;
        bit ok;
        n = q.size();
        lc = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                s = (i == la) ? ls : sp;
                idle = s - 1;
                if (alone && i == ea && idle < 1) idle = 1;
                for (int k = 0; k < idle; k++) begin
                    bus.i_rx_err = alone && i == ea && k == 0;
                    tick();
                end
                bus.i_rx_err = 1'b0;
            end
            bus.i_rx_data  = q[i];
            bus.i_rx_valid = 1'b1;
            bus.i_rx_err   = !alone && i == ea;
            lc = cyc;
            tick();
            bus.i_rx_valid = 1'b0;
            bus.i_rx_err   = 1'b0;
        end
        if (mode == 0) return;
        ok = n >= 4 && n <= MAX_LEN && !(la > 0 && la < n && ls - 1 > T15) &&
             !(ea > 0 && ea < n) && crc16(q) == 16'h0000 &&
             (q[0] == bus.i_my_addr || q[0] == 8'h00);
        exp_ev.push_back(ok);
        exp_c.push_back(lc);
        if (ok && mode == 1) for (int i = 0; i <= n - 3; i++) exp_b.push_back({i == n - 3, q[i]});
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (!bus.o_busy && exp_ev.size() == 0 && exp_b.size() == 0) return;
        end
        checks++;
        fails++;
        $display("FAIL wait_done: timeout busy=%0d events=%0d bytes=%0d", bus.o_busy, exp_ev.size(), exp_b.size());
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check(name, {bus.o_m_valid, bus.o_frame_ok, bus.o_frame_err}, 3'b000);
        tick();
    endtask

    initial begin
        bus.i_m_ready = 1'b1;
        forever begin
            tick();
            bus.i_m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? !bus.i_m_ready : 1'b0;
        end
    end

    initial begin
        bit stall;
        bit ev;
        int c0, lat;
        logic [7:0] hd;
        logic hl;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall) check("stall_hold", {bus.o_m_valid, bus.o_m_last, bus.o_m_data}, {1'b1, hl, hd});
            if (bus.o_frame_ok || bus.o_frame_err) begin
                check("ok_err_exclusive", 16'(bus.o_frame_ok && bus.o_frame_err), 16'h0);
                if (exp_ev.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL frame_result: unexpected pulse ok=%0d err=%0d", bus.o_frame_ok, bus.o_frame_err);
                end else begin
                    ev = exp_ev.pop_front();
                    c0 = exp_c.pop_front();
                    check("frame_result", 16'(bus.o_frame_ok), 16'(ev));
                    lat = cyc - c0;
                    checks++;
                    if (lat < T35 || lat > T35 + 6) begin
                        fails++;
                        $display("FAIL frame_latency: got %0d expected %0d..%0d", lat, T35, T35 + 6);
                    end
                    if (bus.o_frame_ok) check("valid_after_ok", 16'(bus.o_m_valid), 16'h0);
                end
            end
            if (bus.o_m_valid && bus.i_m_ready) begin
                xfer++;
                if (exp_b.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL m_byte: unexpected data %h last %0d", bus.o_m_data, bus.o_m_last);
                end else begin
                    check("m_byte", {bus.o_m_last, bus.o_m_data}, 16'(exp_b.pop_front()));
                end
            end
            stall = bus.o_m_valid && !bus.i_m_ready;
            hd = bus.o_m_data;
            hl = bus.o_m_last;
        end
    end

    initial begin
        int base, inj, k, plen, la, ea, r, p;
        bit alone;
        logic [15:0] c;
        cyc = 0; checks = 0; fails = 0; xfer = 0; rdy_mode = 0;
        rst = 1'b0;
        bus.i_rx_data = 8'h00; bus.i_rx_valid = 1'b0; bus.i_rx_err = 1'b0; bus.i_my_addr = 8'h01;
        f1 = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", {bus.o_m_valid, bus.o_m_last, bus.o_frame_ok, bus.o_frame_err, bus.o_busy, bus.o_m_data}, 16'h0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        check("idle_after_silence", 16'(bus.o_busy), 16'h0);
        check("model_crc_residue", crc16(f1), 16'h0000);

        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();
        f = f1; f[7] = 8'hCC;
        run_frame(f, 5, -1, 0, -1, 1'b0, 1); wait_done();
        bus.i_my_addr = 8'h02;
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();
        bus.i_my_addr = 8'h01;
        run_frame(with_crc({8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A}), 5, -1, 0, -1, 1'b0, 1); wait_done();
        run_frame(f1, 5, 4, 20, -1, 1'b0, 1); wait_done();
        run_frame(f1, 5, 4, 16, -1, 1'b0, 1); wait_done();
        run_frame(f1, 5, 4, 17, -1, 1'b0, 1); wait_done();
        run_frame(f1, 3, -1, 0, 3, 1'b0, 1); wait_done();
        run_frame(f1, 3, -1, 0, 5, 1'b1, 1); wait_done();
        f = {8'h01};
        for (int i = 0; i < 15; i++) f.push_back(8'($urandom_range(0, 255)));
        run_frame(with_crc(f), 2, -1, 0, -1, 1'b0, 1); wait_done();
        f = {8'h01};
        for (int i = 0; i < 13; i++) f.push_back(8'($urandom_range(0, 255)));
        run_frame(with_crc(f), 2, -1, 0, -1, 1'b0, 1); wait_done();
        run_frame(with_crc({8'h01, 8'h07}), 4, -1, 0, -1, 1'b0, 1); wait_done();
        run_frame(with_crc({8'h01}), 4, -1, 0, -1, 1'b0, 1); wait_done();

        rdy_mode = 1;
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();
        rdy_mode = 0;

        base = xfer;
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1);
        for (k = 0; k < 500 && xfer < base + 2; k++) tick();
        check("inject_reached", 16'(xfer >= base + 2), 16'h1);
        bus.i_rx_data = 8'h55; bus.i_rx_valid = 1'b1; inj = cyc;
        tick();
        bus.i_rx_valid = 1'b0;
        for (k = 0; k < 500 && bus.o_busy; k++) tick();
        check("silence_after_inject", 16'(cyc - inj >= T35), 16'h1);
        wait_done();
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();

        run_frame({8'h01, 8'h03, 8'h00}, 5, -1, 0, -1, 1'b0, 0);
        reset_pulse("reset_in_receive");
        wait_done();
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();

        rdy_mode = 2;
        run_frame(f1, 5, -1, 0, -1, 1'b0, 2);
        for (k = 0; k < 500 && !bus.o_m_valid; k++) tick();
        check("deliver_started", 16'(bus.o_m_valid), 16'h1);
        repeat (3) tick();
        reset_pulse("reset_in_deliver");
        rdy_mode = 0;
        wait_done();
        run_frame(f1, 5, -1, 0, -1, 1'b0, 1); wait_done();

        for (int t = 0; t < 40; t++) begin
            f = {};
            plen = $urandom_range(0, 16);
            for (int i = 0; i < plen; i++) f.push_back(8'($urandom_range(0, 255)));
            if (plen > 0) begin
                r = $urandom_range(0, 19);
                f[0] = r < 10 ? 8'h01 : r < 14 ? 8'h00 : r < 17 ? 8'h02 : f[0];
            end
            c = crc16(f);
            f.push_back(c[7:0]);
            f.push_back(c[15:8]);
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(0, f.size() - 1);
                f[p] = f[p] ^ (8'h01 << $urandom_range(0, 7));
            end
            la = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, f.size() - 1)) : -1;
            ea = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, f.size() - 1)) : -1;
            alone = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 1);
            run_frame(f, $urandom_range(1, 6), la, $urandom_range(12, 22), ea, alone, 1);
            wait_done();
        end
        rdy_mode = 0;
        repeat (5) tick();
        check("events_drained", 16'(exp_ev.size()), 16'h0);
        check("bytes_drained", 16'(exp_b.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
